cmp_scheduler: RTL and testbench
================================

CMP_SCHEDULER -- requirements
Module: cmp_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 4, meaning the operand width in bits (2..16).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  N  per-requester compare request.
REQ-006 The block SHALL have port req_a  input  N*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 The block SHALL have port req_b  input  N*W  operand B; same packing as req_a.
REQ-008 The block SHALL have port req_ready  output  N  per-requester accept; at most one bit high.
REQ-009 The block SHALL have port resp_valid  output  1  result available.
REQ-010 The block SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-011 The block SHALL have port resp_id  output  clog2(N)  index of the requester that owns the result.
REQ-012 The block SHALL have port resp_y  output  3  one-hot {Y2,Y1,Y0}: 100 A>B, 010 A=B, 001 A<B.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, SCAN, DONE.
REQ-015 The block SHALL, in IDLE, assert req_ready[g] combinationally for the round-robin winner g among asserted req_valid bits, and SHALL keep all other req_ready bits low.
REQ-016 The block SHALL search for the winner starting at the priority pointer, and SHALL wrap from N-1 to 0.
REQ-017 The block SHALL, on a handshake with requester g, capture A, B and g, set the pointer to (g+1) mod N, set the bit index to W-1, and enter SCAN.
REQ-018 The block SHALL hold req_ready low in SCAN and DONE, and SHALL ignore req_valid changes in those states.
REQ-019 The block SHALL, in SCAN, compare A[idx] against B[idx], one bit per cycle, MSB first.
REQ-020 The block SHALL, when A[idx] differs from B[idx], register 100 (A bit 1) or 001 (B bit 1) into resp_y and enter DONE.
REQ-021 The block SHALL, when the bits are equal and idx>0, decrement idx and remain in SCAN.
REQ-022 The block SHALL, when the bits are equal and idx=0, register 010 and enter DONE.
REQ-023 The block SHALL meet this latency: handshake in cycle t, deciding SCAN cycle t+k (k = 1..W), resp_valid high from cycle t+k+1.
REQ-024 The block SHALL therefore assert resp_valid at t+2 when the MSBs differ, and at t+W+1 when A=B.
REQ-025 The block SHALL, in DONE, hold resp_valid high with resp_y and resp_id stable until resp_ready is sampled high, then return to IDLE.
REQ-026 The block SHALL accept the next request no earlier than the cycle after that return to IDLE.
REQ-027 The block SHALL, when no req_valid is asserted in IDLE, leave the pointer unchanged and stay in IDLE.
REQ-028 The block SHALL treat simultaneous requests from all N requesters as granted in strict rotation from the pointer, with no requester starved.

Reset
REQ-029 The block SHALL, while rst_n is low, force state IDLE, pointer 0, idx W-1, req_ready 0, resp_valid 0, resp_y 000, resp_id 0, busy 0.
REQ-030 The block SHALL, on reset asserted mid-SCAN or mid-DONE, discard the pending result without asserting resp_valid.
REQ-031 The block SHALL permit the first grant in the first clock edge after rst_n deasserts.

Structure
REQ-032 The block SHALL place the result encodings (RES_GT=100, RES_EQ=010, RES_LT=001) and the FSM state type in shared package cmp_pkg.
REQ-033 The block SHALL implement the pointer and grant logic as sub-module rr_arbiter (inputs req, ptr; output one-hot grant).
REQ-034 The block SHALL keep the datapath in the top level as a single-bit serial compare.

Verification
REQ-035 The bench SHALL check: requester 0 sends A=1001, B=0111 -> resp_y=100, resp_id=0, resp_valid two cycles after the handshake.
REQ-036 The bench SHALL check: requester 2 sends A=B=1010 -> resp_y=010 at t+5, with busy high from t+1 to t+5.
REQ-037 The bench SHALL check: requester 1 sends A=0110, B=0111 -> resp_y=001 at t+5 (decided at the LSB).
REQ-038 The bench SHALL check: all 4 requesters valid continuously from reset -> grants in the order 0, 1, 2, 3, 0, with exactly one req_ready high per grant.
REQ-039 The bench SHALL check: resp_ready held low for 5 cycles in DONE -> resp_valid, resp_y and resp_id stay stable and no new req_ready is asserted.
REQ-040 The bench SHALL check: rst_n pulsed low during SCAN -> all outputs return to 0 immediately, no response is issued, and the pointer returns to 0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings and FSM state type for the serial compare scheduler.
// Result codes are one-hot {GT, EQ, LT}.
package cmp_pkg;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only meaningful when the two bits differ: the side holding the 1 is larger.
  function automatic logic [2:0] bit_result(input logic a_bit, input logic b_bit);
    logic [2:0] res;
    res = RES_LT;
    if (a_bit && !b_bit) res = RES_GT;
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request found scanning upward from ptr,
// wrapping from N-1 to 0. Output is one-hot, or zero when nothing is requested.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_scheduler.sv
// Round-robin scheduler in front of a bit-serial magnitude comparator.
// One request is compared MSB-first, one bit per cycle, then held until consumed.
module cmp_scheduler
  import cmp_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [$clog2(N)-1:0] resp_id,
  output logic [2:0]           resp_y,
  output logic                 busy
);

  localparam int IDW = $clog2(N);
  localparam int IXW = $clog2(W);

  state_t         state, state_d;
  logic [IDW-1:0] ptr, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] gid;
  logic [IXW-1:0] idx, idx_d;
  logic [2:0]     y_q, y_d;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   a_sel, b_sel;
  logic [N-1:0]   grant;
  logic           idle_live;
  logic           hs;
  logic           a_bit, b_bit;

  rr_arbiter #(
    .N  (N),
    .PW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Grants are suppressed while reset is held so nothing can handshake then.
  assign idle_live = (state == ST_IDLE) && rst_n;
  assign req_ready = idle_live ? grant : '0;
  assign hs        = idle_live && (|req_valid);

  always_comb begin
    gid = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) gid = IDW'(k);
    end
  end

  assign a_sel = req_a[int'(gid)*W +: W];
  assign b_sel = req_b[int'(gid)*W +: W];
  assign a_bit = a_q[idx];
  assign b_bit = b_q[idx];

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = idx;
    id_d    = id_q;
    y_d     = y_q;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          id_d    = gid;
          ptr_d   = (gid == IDW'(N-1)) ? '0 : gid + 1'b1;
          idx_d   = IXW'(W-1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (a_bit != b_bit) begin
          y_d     = bit_result(a_bit, b_bit);
          state_d = ST_DONE;
        end else if (idx == '0) begin
          y_d     = RES_EQ;
          state_d = ST_DONE;
        end else begin
          idx_d = idx - IXW'(1);
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx   <= IXW'(W-1);
      id_q  <= '0;
      y_q   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      idx   <= idx_d;
      id_q  <= id_d;
      y_q   <= y_d;
    end
  end

  // Operands are pure data: only ever read after a handshake has loaded them.
  always_ff @(posedge clk) begin
    if (hs) begin
      a_q <= a_sel;
      b_q <= b_sel;
    end
  end

  assign resp_valid = (state == ST_DONE);
  assign resp_id    = id_q;
  assign resp_y     = y_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cmp_scheduler.sv
// Directed bench for cmp_scheduler: table of single-requester compares plus
// hand sequences for rotation, response back-pressure and mid-scan reset.
module tb_cmp_scheduler;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [2:0]     resp_y;
  logic           busy;

  int n_checks;
  int n_errors;

  cmp_scheduler #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] y;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         lat;
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    @(negedge clk);
    req_valid = onehot;
    req_a = '0;
    req_b = '0;
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    #1;
    chk("grant", {28'd0, req_ready}, {28'd0, onehot});
    @(posedge clk);
    #1 req_valid = '0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      chk("busy_during", {31'd0, busy}, 32'd1);
      if (resp_valid) break;
      if (lat > 20) begin
        chk("resp_timeout", 32'd0, 32'd1);
        break;
      end
    end
    chk("latency", lat, v.lat);
    chk("resp_y", {29'd0, resp_y}, {29'd0, v.y});
    chk("resp_id", {30'd0, resp_id}, v.id);
    req_valid = '1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_y", {29'd0, resp_y}, {29'd0, v.y});
      chk("hold_id", {30'd0, resp_id}, v.id);
      chk("hold_no_ready", {28'd0, req_ready}, 32'd0);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", {31'd0, resp_valid}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   order[5];
    int   ng;
    int   cyc;
    int   first_cyc;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    vecs[0] = '{0, 4'b1001, 4'b0111, 3'b100, 2, 0};
    vecs[1] = '{2, 4'b1010, 4'b1010, 3'b010, 5, 0};
    vecs[2] = '{1, 4'b0110, 4'b0111, 3'b001, 5, 0};
    vecs[3] = '{3, 4'b0100, 4'b0000, 3'b100, 3, 0};
    vecs[4] = '{0, 4'b0000, 4'b1000, 3'b001, 2, 0};
    vecs[5] = '{1, 4'b0011, 4'b0010, 3'b100, 5, 0};
    vecs[6] = '{3, 4'b0000, 4'b0000, 3'b010, 5, 0};
    vecs[7] = '{2, 4'b1100, 4'b1110, 3'b001, 4, 5};

    // Reset state, with requests pending to show grants stay masked.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_y", {29'd0, resp_y}, 32'd0);
    chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Rotation: all requesters valid straight out of reset.
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = 16'h8888;
    req_b      = 16'h0000;
    resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0;
    cyc = 0;
    first_cyc = -1;
    while (ng < 5 && cyc < 100) begin
      #1;
      if (req_ready != '0) begin
        chk("rot_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
        for (int k = 0; k < N; k++) if (req_ready[k]) order[ng] = k;
        if (ng == 0) first_cyc = cyc;
        ng++;
      end
      if (ng < 5) begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    chk("rot_count", ng, 5);
    chk("rot_first_cycle", first_cyc, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("rot_order%0d", k), order[k], k % N);

    // Put one request in SCAN, then pulse reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_a = 16'h0A00;
    req_b = 16'h0A00;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_id", {30'd0, resp_id}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_resp_y", {29'd0, resp_y}, 32'd0);
    chk("mid_rst_resp_id", {30'd0, resp_id}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    req_valid = 4'hF;
    #1;
    chk("post_rst_ptr0", {28'd0, req_ready}, 32'd1);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
